// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// requester slot numbers and the hard-wired zero register index.
package reg_write_arbiter_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 3;
  localparam int NUM_REQ    = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  localparam int ZERO_REG = 0;

  localparam logic [1:0] PTR_ILLEGAL = 2'd3;

  // Round-robin successor of a requester index; wraps 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: lowest eligible requester
// at or after the pointer wins; returns a one-hot winner and a valid flag.
module rr_pick3
  import reg_write_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_first;
  logic [1:0]         start;

  assign elig  = req & mask;
  assign start = (ptr == PTR_ILLEGAL) ? 2'd0 : ptr;
  assign valid = |elig;

  // Rotate so the search start sits at bit 0, isolate the lowest set bit,
  // then rotate back to requester numbering.
  always_comb begin
    rot = elig;
    case (start)
      2'd1:    rot = {elig[0], elig[2:1]};
      2'd2:    rot = {elig[1:0], elig[2]};
      default: rot = elig;
    endcase
  end

  assign rot_first = rot & (~rot + 3'd1);

  always_comb begin
    winner = rot_first;
    case (start)
      2'd1:    winner = {rot_first[1:0], rot_first[2]};
      2'd2:    winner = {rot_first[0], rot_first[2:1]};
      default: winner = rot_first;
    endcase
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates three register-file write sources (ALU, load, link) onto a
// single registered write port with round-robin fairness.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    grant,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
);

  logic [1:0]    ptr_reg;
  logic [2:0]    winner;
  logic          win_valid;
  logic [1:0]    win_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // A requester granted last cycle is masked out so it cannot win twice in a row.
  rr_pick3 u_pick (
    .req    (req),
    .mask   (~grant),
    .ptr    (ptr_reg),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx  = 2'(REQ_ALU);
    sel_addr = addr0;
    sel_data = data0;
    if (winner[REQ_MEM]) begin
      win_idx  = 2'(REQ_MEM);
      sel_addr = addr1;
      sel_data = data1;
    end else if (winner[REQ_LINK]) begin
      win_idx  = 2'(REQ_LINK);
      sel_addr = addr2;
      sel_data = data2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 2'd0;
      grant   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else if (stall) begin
      grant <= '0;
      wr_en <= 1'b0;
      busy  <= |req;
    end else begin
      grant <= winner;
      busy  <= |(req & ~winner);
      if (win_valid) begin
        ptr_reg <= next_ptr(win_idx);
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        // Writes to the zero register still consume a grant but never strobe the bank.
        wr_en   <= (sel_addr != AW'(ZERO_REG));
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a round-robin reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_reg_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  wire  [AW-1:0] addr0 = a[0];
  wire  [AW-1:0] addr1 = a[1];
  wire  [AW-1:0] addr2 = a[2];
  wire  [DW-1:0] data0 = d[0];
  wire  [DW-1:0] data1 = d[1];
  wire  [DW-1:0] data2 = d[2];
  logic [2:0]    grant;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  reg_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Reference model state
  int            m_ptr = 0;
  logic [2:0]    m_grant = '0;
  logic          m_wr_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int win;
    if (reset) begin
      m_ptr = 0; m_grant = '0; m_wr_en = 0; m_addr = '0; m_data = '0; m_busy = 0;
    end else if (stall) begin
      m_grant = '0; m_wr_en = 0; m_busy = (req != 0);
    end else begin
      win = -1;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (win < 0 && req[c] && !m_grant[c]) win = c;
      end
      if (win >= 0) begin
        m_grant = 3'(1 << win);
        m_addr  = a[win];
        m_data  = d[win];
        m_wr_en = (a[win] != 0);
        m_ptr   = (win + 1) % 3;
      end else begin
        m_grant = '0;
        m_wr_en = 0;
      end
      m_busy = ((req & ~m_grant) != 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("model_grant", 32'(grant), 32'(m_grant));
      chk("model_wr_en", 32'(wr_en), 32'(m_wr_en));
      chk("model_wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("model_wr_data", 32'(wr_data), 32'(m_data));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_ptr", 32'(dut.ptr_reg), 32'(m_ptr));
    end
  end

  task automatic step(input logic [2:0] r, input logic s, input logic rst);
    @(negedge clk);
    req = r; stall = s; reset = rst;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [2:0] exp_g;
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    step(3'b000, 0, 1);
    checking = 1'b1;
    step(3'b000, 0, 1);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_wr_data", 32'(wr_data), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Single ALU write
    a[0] = 3; d[0] = 16'hBEEF;
    step(3'b001, 0, 0);
    chk("alu_grant", 32'(grant), 32'h1);
    chk("alu_wr_en", 32'(wr_en), 32'h1);
    chk("alu_wr_addr", 32'(wr_addr), 32'h3);
    chk("alu_wr_data", 32'(wr_data), 32'hBEEF);
    chk("alu_ptr", 32'(dut.ptr_reg), 32'h1);
    step(3'b000, 0, 0);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_hold_addr", 32'(wr_addr), 32'h3);

    // All three requesting from ptr=0
    step(3'b000, 0, 1);
    a[0] = 3; d[0] = 16'hA000; a[1] = 5; d[1] = 16'hB111; a[2] = 7; d[2] = 16'hC222;
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 0, 0);
      exp_g = 3'(1 << (i % 3));
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_wr_data", 32'(wr_data), 32'(d[i % 3]));
    end
    step(3'b000, 0, 0);

    // Write to zero register: granted, no strobe
    a[1] = 0; d[1] = 16'h1234;
    step(3'b010, 0, 0);
    chk("zero_grant", 32'(grant), 32'h2);
    chk("zero_wr_en", 32'(wr_en), 32'h0);
    step(3'b000, 0, 0);

    // Stall holds everything, then release
    step(3'b000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(3'b101, 1, 0);
      chk("stall_grant", 32'(grant), 32'h0);
      chk("stall_wr_en", 32'(wr_en), 32'h0);
      chk("stall_busy", 32'(busy), 32'h1);
      chk("stall_ptr", 32'(dut.ptr_reg), 32'h0);
    end
    step(3'b101, 0, 0);
    chk("unstall_grant", 32'(grant), 32'h1);
    step(3'b000, 0, 0);

    // Reset dominates request
    step(3'b011, 0, 1);
    chk("rstdom_grant", 32'(grant), 32'h0);
    chk("rstdom_wr_en", 32'(wr_en), 32'h0);
    chk("rstdom_ptr", 32'(dut.ptr_reg), 32'h0);
    step(3'b011, 0, 0);
    chk("postrst_grant", 32'(grant), 32'h1);
    step(3'b000, 0, 0);

    // Lone requester held: grant every other cycle
    for (int i = 0; i < 8; i++) begin
      step(3'b001, 0, 0);
      chk("lone_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("lone_busy", 32'(busy), (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    step(3'b000, 0, 0);

    // Mixed traffic, model-checked only
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 3; j++) begin
        a[j] = 3'($urandom_range(0, 7));
        d[j] = 16'($urandom);
      end
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end

    checking = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DW, 16, data width of every write port and of the register bank.
REQ-002 Parameter AW, 3, register index width (8 registers; index 0 is the hard-wired zero register).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 stall  input  1  processor stall; when high, no grant issued and arbitration state held.
REQ-006 req  input  3  per-requester write request (bit0 ALU writeback, bit1 memory load, bit2 link/PC save).
REQ-007 addr0/addr1/addr2  input  AW each  target register index of requester n.
REQ-008 data0/data1/data2  input  DW each  write data of requester n.
REQ-009 grant  output  3  one-hot, registered, one-cycle pulse to the winning requester.
REQ-010 wr_en  output  1  registered write strobe to the register bank.
REQ-011 wr_addr  output  AW  registered register index for the write.
REQ-012 wr_data  output  DW  registered write data.
REQ-013 busy  output  1  registered; high when any req bit was pending and not granted in the previous cycle.

Function
REQ-014 The block SHALL issue at most one grant per cycle, always one-hot or zero.
REQ-015 Arbitration SHALL be round-robin using a 2-bit pointer ptr (values 0..2); search order ptr, ptr+1, ptr+2 modulo 3.
REQ-016 Eligibility: req[n]=1 and grant[n]=0 in the current output (a just-granted requester is not re-granted on the immediately following cycle).
REQ-017 Latency: request sampled at edge k SHALL yield grant, wr_en, wr_addr, wr_data valid during cycle k+1 (one-cycle registered latency).
REQ-018 On a grant to requester n, ptr SHALL become (n+1) mod 3 at the same edge; with no grant ptr holds.
REQ-019 wr_addr/wr_data SHALL capture addrn/datan of the winner; with no winner they hold previous values.
REQ-020 Writes to index 0 SHALL be granted (grant pulses) but wr_en SHALL be 0 for that cycle.
REQ-021 Requester handshake: requester holds req, addr, data stable until it sees its grant, then drops or presents a new request next cycle.
REQ-022 stall=1 at an edge: grant and wr_en forced 0, ptr held, busy=1 if any req set.
REQ-023 req=0: grant=0, wr_en=0, busy=0, ptr held.
REQ-024 ptr value 3 (illegal) SHALL be treated as 0 and corrected to the next legal value on the next grant.
REQ-025 Requests are not queued; a dropped req before grant is lost without error.

Reset
REQ-026 reset=1 at an edge SHALL set ptr=0, grant=0, wr_en=0, wr_addr=0, wr_data=0, busy=0.
REQ-027 reset SHALL dominate stall and req in the same cycle; an in-flight grant is discarded and no write occurs.
REQ-028 First cycle after reset release SHALL arbitrate normally starting from ptr=0.

Structure
REQ-029 Shared package SHALL hold DW/AW defaults, requester index constants (REQ_ALU=0, REQ_MEM=1, REQ_LINK=2) and the zero-register index constant.
REQ-030 One sub-module rr_pick3 (combinational: req, eligibility mask, ptr -> one-hot winner, valid) is natural; all registers stay in reg_write_arbiter.

Verification
REQ-031 Reset then req=3'b001, addr0=3, data0=16'hBEEF -> next cycle grant=001, wr_en=1, wr_addr=3, wr_data=BEEF, ptr=1.
REQ-032 req=3'b111 held 6 cycles from ptr=0 -> grants 001,010,100,001,010,100, each with matching addr/data.
REQ-033 req=3'b010, addr1=0, data1=16'h1234 -> grant=010, wr_en=0.
REQ-034 req=3'b101 with stall=1 for 3 cycles -> grant=0, wr_en=0, busy=1, ptr unchanged; stall drop -> grant=001 next cycle.
REQ-035 req=3'b011 and reset=1 same edge -> all outputs 0, ptr=0; next cycle with req still 011 -> grant=001.
REQ-036 req[0] held alone continuously -> grant=001 every other cycle (never two consecutive), busy=1 in the gap cycles.
